// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller for a SIB/TDR chain.
//   Runs the 16-state TAP FSM and holds the instruction register, BYPASS and
//   (optionally) IDCODE. Decodes capture/shift/update strobes for the external
//   chain and retimes the selected serial source onto TDO on negedge tck.
// Optional feature macro: JTAG_TAP_IDCODE_EN
//   defined   -> 32-bit IDCODE register, reset opcode = OP_IDCODE
//   undefined -> no IDCODE register, OP_IDCODE decodes as BYPASS, reset opcode = all-ones
// Ports:
//   tck, trstb      test clock, async active-low test reset
//   tms, tdi        pin inputs sampled on posedge tck
//   tdo, tdo_en     pin output and enable, registered on negedge tck
//   chain_tdi/_tdo  serial path to/from the external chain
//   chain_sel       IR == OP_CHAIN
//   capture_dr, shift_dr, update_dr
//                   chain strobes, decoded from the state register
//   ir              current instruction
//   tlr             FSM in Test-Logic-Reset
module jtag_tap_ctrl #(
   parameter int unsigned          IR_WIDTH  = 4,
   parameter logic [IR_WIDTH-1:0]  OP_IDCODE = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0]  OP_CHAIN  = IR_WIDTH'(2),
   parameter logic [31:0]          IDCODE    = 32'h1000_0001
) (
   input  logic                tck,
   input  logic                trstb,
   input  logic                tms,
   input  logic                tdi,
   output logic                tdo,
   output logic                tdo_en,
   output logic                chain_tdi,
   input  logic                chain_tdo,
   output logic                chain_sel,
   output logic                capture_dr,
   output logic                shift_dr,
   output logic                update_dr,
   output logic [IR_WIDTH-1:0] ir,
   output logic                tlr
);

   // Elaboration-time parameter sanity checks
   if (IR_WIDTH < 2) begin : g_bad_ir_width
      $error("jtag_tap_ctrl: IR_WIDTH must be >= 2");
   end
   if (IDCODE[0] != 1'b1) begin : g_bad_idcode
      $error("jtag_tap_ctrl: IDCODE bit0 must be 1");
   end
   if (OP_IDCODE == OP_CHAIN) begin : g_bad_opcodes
      $error("jtag_tap_ctrl: OP_IDCODE and OP_CHAIN must differ");
   end

`ifdef JTAG_TAP_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] RST_OP = OP_IDCODE;
`else
   localparam logic [IR_WIDTH-1:0] RST_OP = '1;
`endif

   typedef enum logic [3:0] {
      TLR, RTI,
      SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_state_e;

   tap_state_e          state_q, state_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
   logic                bypass_q, bypass_d;
   logic                tdo_q, tdo_d;
   logic                tdo_en_q, tdo_en_d;
   logic                dr_tdo;
`ifdef JTAG_TAP_IDCODE_EN
   logic [31:0]         idcode_sr_q, idcode_sr_d;
   logic                idcode_sel;
   assign idcode_sel = (ir_q == OP_IDCODE);
`endif

   // Instruction decode and chain strobes (combinational from state/IR registers)
   assign chain_sel  = (ir_q == OP_CHAIN);
   assign chain_tdi  = tdi;
   assign capture_dr = chain_sel && (state_q == CAP_DR);
   assign shift_dr   = chain_sel && (state_q == SH_DR);
   assign update_dr  = chain_sel && (state_q == UPD_DR);
   assign tlr        = (state_q == TLR);
   assign ir         = ir_q;
   assign tdo        = tdo_q;
   assign tdo_en     = tdo_en_q;

   // TAP state register and posedge data registers
   always_ff @(posedge tck or negedge trstb) begin
      if (!trstb) begin
         state_q     <= TLR;
         ir_q        <= RST_OP;
         ir_sr_q     <= '0;
         bypass_q    <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
         idcode_sr_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         ir_sr_q     <= ir_sr_d;
         bypass_q    <= bypass_d;
`ifdef JTAG_TAP_IDCODE_EN
         idcode_sr_q <= idcode_sr_d;
`endif
      end
   end

   // TDO retime on the falling edge
   always_ff @(negedge tck or negedge trstb) begin
      if (!trstb) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

   // Next-state logic of the 1149.1 diagram
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:    state_d = tms ? TLR    : RTI;
         RTI:    state_d = tms ? SEL_DR : RTI;
         SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
         PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
         EX2_DR: state_d = tms ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms ? SEL_DR : RTI;
         SEL_IR: state_d = tms ? TLR    : CAP_IR;
         CAP_IR: state_d = tms ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
         PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
         EX2_IR: state_d = tms ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   // IR / DR register updates and TDO source selection
   always_comb begin
      ir_d        = ir_q;
      ir_sr_d     = ir_sr_q;
      bypass_d    = bypass_q;
      tdo_d       = 1'b0;
      tdo_en_d    = 1'b0;
      dr_tdo      = bypass_q;
`ifdef JTAG_TAP_IDCODE_EN
      idcode_sr_d = idcode_sr_q;
      if (idcode_sel) dr_tdo = idcode_sr_q[0];
`endif
      if (chain_sel) dr_tdo = chain_tdo;

      // ir only moves on leaving Update-IR, or is pinned while in TLR
      if (state_q == TLR)         ir_d = RST_OP;
      else if (state_q == UPD_IR) ir_d = ir_sr_q;

      if (state_q == CAP_IR)     ir_sr_d = IR_WIDTH'(1);
      else if (state_q == SH_IR) ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};

      if (state_q == CAP_DR)     bypass_d = 1'b0;
      else if (state_q == SH_DR) bypass_d = tdi;

`ifdef JTAG_TAP_IDCODE_EN
      if (state_q == CAP_DR)     idcode_sr_d = IDCODE;
      else if (state_q == SH_DR) idcode_sr_d = {tdi, idcode_sr_q[31:1]};
`endif

      if (state_q == SH_IR) begin
         tdo_d    = ir_sr_q[0];
         tdo_en_d = 1'b1;
      end else if (state_q == SH_DR) begin
         tdo_d    = dr_tdo;
         tdo_en_d = 1'b1;
      end
   end

endmodule
